// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, fault codes and address decode for the instruction fetch block
package imem_pkg;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_OK       = 2'b00;
    localparam fault_t FAULT_MISALIGN = 2'b01;
    localparam fault_t FAULT_RANGE    = 2'b10;

    // Misalignment wins over range; an address below base underflows and is out of range.
    function automatic fault_t addr_check(input logic [31:0] a, input logic [31:0] base,
                                          input int unsigned depth);
        logic [31:0] off;
        off = a - base;
        return (a[1:0] != 2'b00) ? FAULT_MISALIGN :
               (a < base || (off >> 2) >= depth) ? FAULT_RANGE : FAULT_OK;
    endfunction
endpackage

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch request/response handshake bundle
//   req_valid/req_ready/req_addr : request channel
//   rsp_valid/rsp_ready/rsp_inst/rsp_addr/rsp_fault : response channel
interface imem_fetch_if;
    import imem_pkg::*;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [31:0] rsp_addr;
    fault_t      rsp_fault;

    modport master (output req_valid, req_addr, rsp_ready,
                    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault);
    modport slave  (input  req_valid, req_addr, rsp_ready,
                    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_fault);
endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction storage, one sync write port, one sync read port
//   clk : clock
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr/o_rdata : read port, o_rdata holds until the next read
module imem_array
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] NOP_INST = NOP_DEFAULT,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH] = '{default: NOP_INST};
    logic [31:0] r_rdata       = NOP_INST;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: instruction fetch with one-entry response register and loader port
//   clk, rst      : clock, synchronous active-high reset
//   bus           : fetch request/response handshake (slave side)
//   i_flush       : drop held response and any same-cycle request
//   i_ld_en/i_ld_addr/i_ld_data : loader word write; o_ld_err pulses on a rejected load
//   o_fetch_count : responses delivered
module imem_fetch
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = NOP_DEFAULT,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    imem_fetch_if.slave bus,
    input  logic        i_flush,
    input  logic        i_ld_en,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_err,
    output logic [31:0] o_fetch_count
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]    r_state;
    logic [31:0]   r_addr;
    fault_t        r_fault;
    logic          r_ld_err;
    logic [31:0]   r_count;
    fault_t        w_req_fault;
    fault_t        w_ld_fault;
    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_ld_idx;
    logic          w_accept;
    logic          w_rd;
    logic          w_wr;
    logic          w_take;
    logic [31:0]   w_rdata;

    assign w_req_fault   = addr_check(bus.req_addr, BASE_ADDR, DEPTH);
    assign w_ld_fault    = addr_check(i_ld_addr, BASE_ADDR, DEPTH);
    assign w_req_idx     = AW'((bus.req_addr - BASE_ADDR) >> 2);
    assign w_ld_idx      = AW'((i_ld_addr - BASE_ADDR) >> 2);
    assign bus.req_ready = !rst && !i_flush && !i_ld_en && (r_state == EMPTY || bus.rsp_ready);
    assign w_accept      = bus.req_valid && bus.req_ready;
    // Faulting requests never touch storage, so the read register keeps its last value.
    assign w_rd          = w_accept && w_req_fault == FAULT_OK;
    assign w_wr          = !rst && i_ld_en && w_ld_fault == FAULT_OK;
    assign w_take        = r_state == FULL && bus.rsp_ready && !i_flush;

    imem_array #(.DEPTH(DEPTH), .NOP_INST(NOP_INST)) u_array (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (w_ld_idx),
        .i_wdata (i_ld_data),
        .i_re    (w_rd),
        .i_raddr (w_req_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_addr   <= '0;
            r_fault  <= FAULT_OK;
            r_ld_err <= 1'b0;
            r_count  <= '0;
        end else begin
            r_ld_err <= i_ld_en && w_ld_fault != FAULT_OK;
            r_count  <= r_count + 32'(w_take);
            if (i_flush) begin
                r_state <= EMPTY;
            end else if (w_accept) begin
                r_state <= FULL;
                r_addr  <= bus.req_addr;
                r_fault <= w_req_fault;
            end else if (bus.rsp_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign bus.rsp_valid = r_state == FULL;
    assign bus.rsp_inst  = (r_state == FULL && r_fault == FAULT_OK) ? w_rdata : NOP_INST;
    assign bus.rsp_addr  = r_addr;
    assign bus.rsp_fault = r_fault;
    assign o_ld_err      = r_ld_err;
    assign o_fetch_count = r_count;
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed scoreboard bench for imem_fetch
module tb_imem_fetch;
    import imem_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [1:0]  fault;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_err;
    logic [31:0] fetch_count;

    imem_fetch_if bus();

    imem_fetch #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .i_flush       (flush),
        .i_ld_en       (ld_en),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data),
        .o_ld_err      (ld_err),
        .o_fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [DEPTH];
    rsp_t        q [$];
    logic        exp_full  = 1'b0;
    logic        exp_lderr = 1'b0;
    logic [31:0] exp_cnt   = '0;

    function automatic logic [1:0] fault_of(input logic [31:0] a);
        return (a[1:0] != 2'b00) ? 2'b01 : (a >= 32'(4 * DEPTH)) ? 2'b10 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic rdy, acc, nf;
        rsp_t r;
        #1;
        rdy = !rst && !flush && !ld_en && (!exp_full || bus.rsp_ready);
        chk("req_ready", bus.req_ready, rdy);
        chk("rsp_valid", bus.rsp_valid, exp_full);
        chk("ld_err", ld_err, exp_lderr);
        chk("fetch_count", fetch_count, exp_cnt);
        if (exp_full) begin
            if (q.size() > 0) begin
                chk("rsp_inst", bus.rsp_inst, q[0].inst);
                chk("rsp_addr", bus.rsp_addr, q[0].addr);
                chk("rsp_fault", bus.rsp_fault, q[0].fault);
            end else begin
                checks++;
                errors++;
                $error("FAIL scoreboard observed empty expected entry");
            end
        end
        acc = bus.req_valid && rdy;
        if (rst) begin
            exp_full  = 1'b0;
            exp_cnt   = '0;
            exp_lderr = 1'b0;
            q.delete();
        end else begin
            exp_lderr = ld_en && fault_of(ld_addr) != 2'b00;
            nf = !flush && (acc || (exp_full && !bus.rsp_ready));
            if (exp_full && (flush || bus.rsp_ready)) begin
                if (!flush) exp_cnt++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (acc) begin
                r.addr  = bus.req_addr;
                r.fault = fault_of(bus.req_addr);
                r.inst  = (r.fault == 2'b00) ? mdl[bus.req_addr[5:2]] : NOP;
                q.push_back(r);
            end
            exp_full = nf;
            if (ld_en && fault_of(ld_addr) == 2'b00) mdl[ld_addr[5:2]] = ld_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a, input logic rdy);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.rsp_ready = rdy;
        cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        cycle();
        ld_en = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (n) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = NOP;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_inst", bus.rsp_inst, NOP);
        chk("rst_addr", bus.rsp_addr, 0);
        chk("rst_fault", bus.rsp_fault, 0);
        chk("rst_lderr", ld_err, 0);
        chk("rst_count", fetch_count, 0);
        rst = 1'b0;

        load(32'h0, 32'hA);
        load(32'h4, 32'hB);
        load(32'h8, 32'hC);
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b1);
        idle(2);
        chk("count_b2b", fetch_count, 3);

        fetch(32'h4, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        bus.rsp_ready = 1'b0;
        repeat (3) cycle();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        cycle();
        idle(1);
        chk("count_stall", fetch_count, 4);

        fetch(32'h6, 1'b1);
        fetch(32'h40, 1'b1);
        idle(1);
        load(32'h6, 32'hDEAD);
        load(32'h40, 32'hBEEF);
        idle(2);
        fetch(32'h4, 1'b1);
        idle(1);
        chk("count_fault", fetch_count, 7);

        fetch(32'h10, 1'b0);
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        bus.rsp_ready = 1'b0;
        cycle();
        flush = 1'b0;
        idle(2);
        chk("count_flush", fetch_count, 7);

        fetch(32'h8, 1'b0);
        bus.rsp_ready = 1'b0;
        load(32'h8, 32'h1234);
        cycle();
        bus.rsp_ready = 1'b1;
        cycle();
        fetch(32'h8, 1'b1);
        idle(1);
        chk("count_hold", fetch_count, 9);

        fetch(32'h0, 1'b0);
        rst = 1'b1;
        ld_en = 1'b1;
        ld_addr = 32'h0;
        ld_data = 32'h5555;
        bus.rsp_ready = 1'b0;
        cycle();
        rst = 1'b0;
        ld_en = 1'b0;
        idle(1);
        chk("count_rst", fetch_count, 0);
        fetch(32'h0, 1'b1);
        idle(1);
        chk("count_after_rst", fetch_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit instruction words (power of two, >=2).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address mapped to word 0.
REQ-003 Parameter NOP_INST, default 32'h0000_0013, fill and fault-substitute instruction.
REQ-004 The block SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  fetch request present; req_ready  out  1  request accepted this cycle when both high; req_addr  in  32  byte address.
REQ-007 rsp_valid  out  1  response present; rsp_ready  in  1  consumer takes response; rsp_inst  out  32; rsp_addr  out  32  echoed req_addr; rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range.
REQ-008 flush  in  1  discard pending response and any same-cycle request.
REQ-009 ld_en  in  1; ld_addr  in  32; ld_data  in  32  loader word-write port; ld_err  out  1  one-cycle pulse on rejected load.
REQ-010 fetch_count  out  32  number of responses delivered (rsp_valid && rsp_ready).

Function
REQ-011 Storage SHALL be initialised to NOP_INST at time zero; rst SHALL NOT alter storage contents.
REQ-012 Index = (req_addr - BASE_ADDR) >> 2; in range iff the subtraction does not underflow and index < DEPTH.
REQ-013 Response register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-014 req_ready = !rst && !flush && !ld_en && (EMPTY || rsp_ready), combinational.
REQ-015 An accepted request SHALL produce rsp_valid=1 exactly one cycle later, with rsp_inst, rsp_addr, rsp_fault for that request.
REQ-016 FULL with rsp_ready=0: all rsp_* outputs SHALL hold stable.
REQ-017 FULL with rsp_ready=1 and a new acceptance: stays FULL with new data next cycle (back-to-back, one fetch per cycle).
REQ-018 FULL with rsp_ready=1 and no acceptance: goes EMPTY.
REQ-019 Misaligned (req_addr[1:0]!=0): rsp_fault=01, rsp_inst=NOP_INST; misaligned takes priority over out of range.
REQ-020 Out of range and aligned: rsp_fault=10, rsp_inst=NOP_INST; no storage read.
REQ-021 flush=1: next cycle EMPTY regardless of rsp_ready; fetch_count not incremented for the dropped response.
REQ-022 ld_en=1 with aligned in-range ld_addr: write ld_data at index at clock edge; ld_en takes priority over fetch that cycle.
REQ-023 ld_en=1 with misaligned or out-of-range ld_addr: no write, ld_err=1 next cycle for one cycle.
REQ-024 Load to the word currently held in rsp_inst SHALL NOT change the held response; a later fetch returns the new value.
REQ-025 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-026 With rst=1 at an edge: rsp_valid=0, rsp_inst=NOP_INST, rsp_addr=0, rsp_fault=00, ld_err=0, fetch_count=0, state EMPTY.
REQ-027 rst mid-operation SHALL discard the held response; ld_en in a reset cycle SHALL NOT write.

Structure
REQ-028 Shared package imem_pkg SHALL hold NOP_INST default and fault-code constants (FAULT_OK, FAULT_MISALIGN, FAULT_RANGE).
REQ-029 Storage SHALL be a sub-module imem_array: DEPTH x 32, one synchronous read port, one synchronous write port, NOP initialisation.

Verification
REQ-030 Fetch 0x0,0x4,0x8 back-to-back, rsp_ready=1, after loading 0xA,0xB,0xC -> responses 0xA,0xB,0xC on consecutive cycles, fetch_count=3.
REQ-031 Fetch 0x4, rsp_ready=0 for 3 cycles -> rsp_inst, rsp_addr stable, req_ready=0; release -> fetch_count increments once.
REQ-032 Fetch 0x6 -> fault 01, NOP; fetch 4*DEPTH -> fault 10, NOP; load to 0x6 -> ld_err pulse, memory unchanged.
REQ-033 Fetch 0x10 accepted, flush next cycle with rsp_ready=0 -> rsp_valid=0 following cycle, fetch_count unchanged.
REQ-034 Hold response for 0x8, load 0x8 with 0x1234 -> held value unchanged; refetch 0x8 -> 0x1234.
REQ-035 Assert rst while FULL -> rsp_valid=0, fetch_count=0; storage contents retained on refetch.
